// File: rtl/serial_logic_unit.sv
// Bit-serial logic unit: one 1-bit logic cell processes WIDTH-bit operands LSB first over WIDTH cycles.
// Optional macro SLU_ZERO_FLAG_EN adds a registered zero flag output.
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       S,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SLU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [1:0]       s_q;
  logic [CNT_W-1:0] cnt;
  logic             cl_out;
  logic             last;
  logic [WIDTH-1:0] shift_result;

  cl u_cl (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .s (s_q),
    .y (cl_out)
  );

  assign last = (cnt == CNT_LAST);

  // New bit enters at the MSB so that after WIDTH shifts bit i lines up with operand bit i.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shift_result = cl_out;
    end else begin : g_wn
      assign shift_result = {cl_out, result[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      s_q    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            s_q  <= S;
            cnt  <= '0;
          end
        end
        RUN: begin
          result <= shift_result;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SLU_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  zero <= 1'b0;
    else if (state == RUN && last) zero <= (shift_result == '0);
  end
`endif

endmodule

// 1-bit logic cell: s = 00 and, 01 or, 10 xor, 11 not-a.
module cl (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] s,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (s)
      2'b00: y = a & b;
      2'b01: y = a | b;
      2'b10: y = a ^ b;
      2'b11: y = ~a;
      default: y = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit: table-driven ops through a result queue, plus hand sequences for
// back-to-back, ignored start, mid-op reset and WIDTH=1.
module tb_serial_logic_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   s = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic [1:0]   s1 = '0;
  logic         busy1;
  logic         done1;
  logic [0:0]   result1;
`ifdef SLU_ZERO_FLAG_EN
  logic         zero;
  logic         zero1;
`endif

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   s;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  serial_logic_unit #(.WIDTH(W)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .S(s),
    .busy(busy), .done(done), .result(result)
`ifdef SLU_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  serial_logic_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1), .S(s1),
    .busy(busy1), .done(done1), .result(result1)
`ifdef SLU_ZERO_FLAG_EN
    , .zero(zero1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op);
    a = x;
    b = y;
    s = op;
    start = 1'b1;
    exp_q.push_back(model(x, y, op));
  endtask

  // Called at a negedge while RUN; returns edges until the done cycle and checks the result.
  task automatic wait_done(input string name, output int n);
    logic busy_ok;
    logic [W-1:0] e;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, done, 1'b1);
    chk({name, "_busy_run"}, busy_ok, 1'b1);
    chk({name, "_busy_at_done"}, busy, 1'b0);
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_result"}, result, e);
    end
  endtask

  task automatic no_done_for(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, seen, 1'b0);
  endtask

  initial begin
    int n;
    int n2;
    logic [W-1:0] last_exp;

    vecs[0] = '{8'hF0, 8'h3C, 2'b00, 8'h30};
    vecs[1] = '{8'hA5, 8'h0F, 2'b01, 8'hAF};
    vecs[2] = '{8'hFF, 8'h5A, 2'b10, 8'hA5};
    vecs[3] = '{8'h3C, 8'hFF, 2'b11, 8'hC3};
    vecs[4] = '{8'hAA, 8'h55, 2'b00, 8'h00};
    vecs[5] = '{8'hAA, 8'h55, 2'b01, 8'hFF};
    vecs[6] = '{8'h00, 8'hFF, 2'b10, 8'hFF};
    vecs[7] = '{8'hFF, 8'h00, 2'b11, 8'h00};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_result1", result1, 1'b0);
`ifdef SLU_ZERO_FLAG_EN
    chk("rst_zero", zero, 1'b0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // table ops: known-answer vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      chk($sformatf("vec%0d_model", i), exp_q[exp_q.size()-1], vecs[i].exp);
      @(negedge clk);
      start = 1'b0;
      wait_done($sformatf("vec%0d", i), n);
      chk($sformatf("vec%0d_latency", i), n, W);
`ifdef SLU_ZERO_FLAG_EN
      chk($sformatf("vec%0d_zero", i), zero, (vecs[i].exp == 8'h00));
`endif
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done, 1'b0);
    end

    // random ops
    for (int i = 0; i < 4; i++) begin
      start_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      last_exp = exp_q[exp_q.size()-1];
      @(negedge clk);
      start = 1'b0;
      wait_done($sformatf("rnd%0d", i), n);
      chk($sformatf("rnd%0d_latency", i), n, W);
      @(negedge clk);
    end

    // result holds in IDLE
    a = ~a;
    repeat (3) @(negedge clk);
    chk("result_hold", result, last_exp);

    // back-to-back with start held high
    start_op(8'hA5, 8'h0F, 2'b01);
    @(negedge clk);
    wait_done("b2b0", n);
    start_op(8'hFF, 8'h5A, 2'b10);
    @(negedge clk);
    chk("b2b_done_to_idle", done, 1'b0);
    @(negedge clk);
    wait_done("b2b1", n);
    chk("b2b_gap1", n + 2, W + 2);
    start_op(8'h3C, 8'hFF, 2'b11);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b2", n);
    chk("b2b_gap2", n + 2, W + 2);
    @(negedge clk);

    // start ignored while busy
    start_op(8'hF0, 8'h3C, 2'b00);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h00;
    b = 8'hFF;
    s = 2'b01;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("ign", n);
    chk("ign_latency", n + 5, W);
    no_done_for("ign_no_second", 12);

    // reset mid-op
    start_op(8'hC3, 8'h99, 2'b10);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 8'h00);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    no_done_for("midrst_no_stale", 12);
    start_op(8'h5A, 8'h0F, 2'b00);
    @(negedge clk);
    start = 1'b0;
    wait_done("postrst", n2);
    chk("postrst_latency", n2, W);
    @(negedge clk);

    // WIDTH=1 instance
    a1 = 1'b1;
    b1 = 1'b0;
    s1 = 2'b10;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", busy1, 1'b1);
    chk("w1_done_early", done1, 1'b0);
    @(negedge clk);
    chk("w1_done", done1, 1'b1);
    chk("w1_busy_at_done", busy1, 1'b0);
    chk("w1_result", result1, 1'b1);
`ifdef SLU_ZERO_FLAG_EN
    chk("w1_zero", zero1, 1'b0);
`endif
    @(negedge clk);
    chk("w1_done_pulse", done1, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
